// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 exception/interrupt controller for the write-back stage.
// Synchronises external interrupt lines, arbitrates them against synchronous
// exceptions and eret, holds Status/Cause/EPC/Count/Compare, and issues a PC
// redirect to fetch under a valid/ack handshake.
module cp0_exc_ctrl #(
  parameter int unsigned NUM_IRQ      = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000F500,
  parameter bit          TIMER_EN     = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        exc_pc,
  input  logic               eret,
  input  logic               mtc0,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  input  logic               redirect_ack,
  output logic               busy
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  typedef enum logic {
    S_IDLE,
    S_REDIRECT
  } state_e;

  state_e               state_q;
  logic                 redirect_valid_q;
  logic [31:0]          redirect_pc_q;

  logic [NUM_IRQ-1:0]   sync1_q;
  logic [NUM_IRQ-1:0]   sync2_q;

  logic [7:0]           im_q;
  logic                 exl_q;
  logic                 ie_q;
  logic [4:0]           exccode_q;
  logic [31:0]          epc_q;
  logic [31:0]          count_q;
  logic [31:0]          count_d;
  logic [31:0]          compare_q;
  logic                 timer_ip_q;

  logic [6:0]           hw_ip;
  logic [7:0]           ip;
  logic                 int_req;
  logic                 mtc0_acc;

  // Map synchronised interrupt lines onto IP[14:8]; unused lines read 0
  always_comb begin
    hw_ip = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      hw_ip[k] = sync2_q[k];
    end
  end

  assign ip      = {timer_ip_q & TIMER_EN, hw_ip};
  assign int_req = ie_q & ~exl_q & (|(ip & im_q));

  // mtc0 only takes effect in IDLE when no higher-priority event coincides
  assign mtc0_acc = (state_q == S_IDLE) & mtc0 & ~exc_valid & ~int_req & ~eret;

  // Two-flop synchroniser for the asynchronous interrupt levels
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  // Count free-runs unless loaded by an accepted mtc0
  always_comb begin
    count_d = count_q + 32'd1;
    if (mtc0_acc && cp0_addr == ADDR_COUNT) begin
      count_d = wdata;
    end
  end

  // Count/Compare timer with sticky match flag cleared by a Compare write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      compare_q  <= '1;
      timer_ip_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (mtc0_acc && cp0_addr == ADDR_COMPARE) begin
        compare_q  <= wdata;
        timer_ip_q <= 1'b0;
      end else if (TIMER_EN && count_q == compare_q) begin
        timer_ip_q <= 1'b1;
      end
    end
  end

  // Event arbitration, Status/Cause/EPC updates and the redirect handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      im_q             <= '1;
      exl_q            <= 1'b0;
      ie_q             <= 1'b1;
      exccode_q        <= '0;
      epc_q            <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (exc_valid) begin
            exccode_q <= exc_code;
            if (!exl_q) begin
              epc_q <= exc_pc;
            end
            exl_q            <= 1'b1;
            redirect_pc_q    <= HANDLER_ADDR;
            redirect_valid_q <= 1'b1;
            state_q          <= S_REDIRECT;
          end else if (int_req) begin
            exccode_q        <= '0;
            epc_q            <= exc_pc;
            exl_q            <= 1'b1;
            redirect_pc_q    <= HANDLER_ADDR;
            redirect_valid_q <= 1'b1;
            state_q          <= S_REDIRECT;
          end else if (eret) begin
            exl_q            <= 1'b0;
            redirect_pc_q    <= epc_q;
            redirect_valid_q <= 1'b1;
            state_q          <= S_REDIRECT;
          end else if (mtc0) begin
            if (cp0_addr == ADDR_STATUS) begin
              im_q  <= wdata[15:8];
              exl_q <= wdata[1];
              ie_q  <= wdata[0];
            end else if (cp0_addr == ADDR_EPC) begin
              epc_q <= wdata;
            end
          end
        end
        S_REDIRECT: begin
          if (redirect_ack) begin
            redirect_valid_q <= 1'b0;
            state_q          <= S_IDLE;
          end
        end
        default: begin
          redirect_valid_q <= 1'b0;
          state_q          <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational register read port; Cause is hardware-owned and ignores mtc0
  always_comb begin
    rdata = '0;
    case (cp0_addr)
      ADDR_COUNT:   rdata = TIMER_EN ? count_q : '0;
      ADDR_COMPARE: rdata = TIMER_EN ? compare_q : '0;
      ADDR_STATUS:  rdata = {16'h0000, im_q, 6'b000000, exl_q, ie_q};
      ADDR_CAUSE:   rdata = {16'h0000, ip, 1'b0, exccode_q, 2'b00};
      ADDR_EPC:     rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = redirect_valid_q;

endmodule
